// File: rtl/dmac_pkg.sv
// Shared types and encodings for the DMAC request controller.
// Holds the FSM state enum, AHB HTRANS/HRESP codes and con_sel selects.
package dmac_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BUSREQ,
        CFG,
        SETTLE,
        RUN,
        RELEASE
    } state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] SEL_CH1 = 2'b00;
    localparam logic [1:0] SEL_CH2 = 2'b01;
    localparam logic [1:0] SEL_CFG = 2'b10;

    localparam logic [1:0] HRESP_OKAY = 2'b00;
    localparam logic [1:0] HRESP_ERR  = 2'b01;

endpackage

// File: rtl/dmac_cfg_fetch.sv
// Pipelined AHB descriptor fetch: address counter, data counter, strobe decode.
// Ports: i_start (high while fetching, low clears), i_hready, i_hresp,
//        o_htrans, o_addr_sel, o_stb {SAddr,DAddr,Trans_sz,Ctrl}, o_done, o_err.
module dmac_cfg_fetch #(
    parameter int         CFG_WORDS = 4,
    parameter logic [1:0] HRESP_ERR = dmac_pkg::HRESP_ERR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic       i_hready,
    input  logic [1:0] i_hresp,
    output logic [1:0] o_htrans,
    output logic [1:0] o_addr_sel,
    output logic [3:0] o_stb,
    output logic       o_done,
    output logic       o_err
);
    import dmac_pkg::*;

    localparam int            CW   = $clog2(CFG_WORDS);
    localparam logic [CW-1:0] LAST = CW'(CFG_WORDS - 1);

    logic [CW-1:0] r_a;
    logic [CW-1:0] r_d;
    logic          r_a_done;
    logic          r_dv;

    logic w_addr_act;
    logic w_err;
    logic w_cap;

    assign w_addr_act = i_start && !r_a_done;
    // The first cycle of a two-cycle ERROR response is acted on; the FSM
    // has already left CFG when the second cycle arrives.
    assign w_err      = i_start && r_dv && (i_hresp == HRESP_ERR);
    assign w_cap      = i_start && r_dv && i_hready && !w_err;

    always_comb begin
        o_htrans = HTRANS_IDLE;
        if (w_addr_act && !w_err) begin
            o_htrans = (r_a == '0) ? HTRANS_NONSEQ : HTRANS_SEQ;
        end
        o_stb = 4'b0000;
        if (w_cap) begin
            o_stb = 4'b1000 >> r_d;
        end
    end

    assign o_addr_sel = 2'(r_a);
    assign o_done     = w_cap && (r_d == LAST);
    assign o_err      = w_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_d      <= '0;
            r_a_done <= 1'b0;
            r_dv     <= 1'b0;
        end else if (!i_start) begin
            r_a      <= '0;
            r_d      <= '0;
            r_a_done <= 1'b0;
            r_dv     <= 1'b0;
        end else if (i_hready) begin
            if (w_addr_act) begin
                if (r_a == LAST) begin
                    r_a_done <= 1'b1;
                end else begin
                    r_a <= r_a + 1'b1;
                end
            end
            // A data phase is pending exactly when an address was accepted.
            r_dv <= w_addr_act;
            if (w_cap) begin
                r_d <= r_d + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmac_req_ctrl.sv
// DMAC request controller: request latch, bus request, descriptor fetch,
// channel enable and request-release handshake. AHB-facing and datapath strobes.
module dmac_req_ctrl #(
    parameter int         CFG_WORDS = 4,
    parameter logic [1:0] HRESP_ERR = dmac_pkg::HRESP_ERR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] DmacReq,
    input  logic [1:0] DmacReq_Reg,
    input  logic       HReady,
    input  logic [1:0] M_HResp,
    input  logic       HGrant,
    input  logic       irq,
    input  logic       C_config,
    output logic       HBusReq,
    output logic [1:0] con_sel,
    output logic       con_en,
    output logic       channel_en_1,
    output logic       channel_en_2,
    output logic       config_write,
    output logic [1:0] config_HTrans,
    output logic [1:0] addr_inc_sel,
    output logic       DmacReq_Reg_en,
    output logic       PeriAddr_reg_en,
    output logic       SAddr_Reg_en,
    output logic       DAddr_Reg_en,
    output logic       Trans_sz_Reg_en,
    output logic       Ctrl_Reg_en,
    output logic       cfg_err
);
    import dmac_pkg::*;

    state_e r_state;
    state_e w_next;
    logic   r_ch2;

    logic       w_req;
    logic       w_fetch;
    logic [3:0] w_stb;
    logic       w_done;
    logic       w_err;

    // Gated with rst so no latch strobe escapes while reset is held.
    assign w_req   = (DmacReq != 2'b00) && !rst;
    assign w_fetch = (r_state == CFG);

    dmac_cfg_fetch #(
        .CFG_WORDS (CFG_WORDS),
        .HRESP_ERR (HRESP_ERR)
    ) u_fetch (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_fetch),
        .i_hready   (HReady),
        .i_hresp    (M_HResp),
        .o_htrans   (config_HTrans),
        .o_addr_sel (addr_inc_sel),
        .o_stb      (w_stb),
        .o_done     (w_done),
        .o_err      (w_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_req) w_next = BUSREQ;
            BUSREQ:  if (HGrant && HReady) w_next = CFG;
            CFG: begin
                if (w_err) begin
                    w_next = RELEASE;
                end else if (w_done) begin
                    w_next = SETTLE;
                end
            end
            SETTLE:  w_next = RUN;
            RUN:     if (irq) w_next = RELEASE;
            RELEASE: if ((DmacReq & DmacReq_Reg) == 2'b00) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Channel choice is frozen in SETTLE, once Ctrl_Reg has been loaded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ch2 <= 1'b0;
        end else if (r_state == SETTLE) begin
            r_ch2 <= C_config;
        end
    end

    always_comb begin
        HBusReq         = 1'b0;
        con_sel         = SEL_CFG;
        con_en          = 1'b0;
        channel_en_1    = 1'b0;
        channel_en_2    = 1'b0;
        DmacReq_Reg_en  = 1'b0;
        PeriAddr_reg_en = 1'b0;
        unique case (r_state)
            IDLE: begin
                DmacReq_Reg_en  = w_req;
                PeriAddr_reg_en = w_req;
            end
            BUSREQ: HBusReq = 1'b1;
            CFG:    HBusReq = 1'b1;
            SETTLE: begin
                HBusReq = 1'b1;
                con_sel = C_config ? SEL_CH2 : SEL_CH1;
                con_en  = 1'b1;
            end
            RUN: begin
                HBusReq      = 1'b1;
                con_sel      = r_ch2 ? SEL_CH2 : SEL_CH1;
                channel_en_1 = !r_ch2;
                channel_en_2 = r_ch2;
            end
            default: ;
        endcase
    end

    assign config_write    = 1'b0;
    assign SAddr_Reg_en    = w_stb[3];
    assign DAddr_Reg_en    = w_stb[2];
    assign Trans_sz_Reg_en = w_stb[1];
    assign Ctrl_Reg_en     = w_stb[0];
    assign cfg_err         = w_err;

endmodule

// File: tb/tb_dmac_req_ctrl.sv
// Directed testbench for dmac_req_ctrl.
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_dmac_req_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] DmacReq;
  logic [1:0] DmacReq_Reg;
  logic       HReady;
  logic [1:0] M_HResp;
  logic       HGrant;
  logic       irq;
  logic       C_config;
  logic       HBusReq;
  logic [1:0] con_sel;
  logic       con_en;
  logic       channel_en_1;
  logic       channel_en_2;
  logic       config_write;
  logic [1:0] config_HTrans;
  logic [1:0] addr_inc_sel;
  logic       DmacReq_Reg_en;
  logic       PeriAddr_reg_en;
  logic       SAddr_Reg_en;
  logic       DAddr_Reg_en;
  logic       Trans_sz_Reg_en;
  logic       Ctrl_Reg_en;
  logic       cfg_err;

  int n_chk  = 0;
  int n_fail = 0;

  logic [3:0] stb;
  logic [1:0] chen;
  assign stb  = {SAddr_Reg_en, DAddr_Reg_en,
                 Trans_sz_Reg_en, Ctrl_Reg_en};
  assign chen = {channel_en_1, channel_en_2};

  always #5 clk = ~clk;

  dmac_req_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .DmacReq         (DmacReq),
    .DmacReq_Reg     (DmacReq_Reg),
    .HReady          (HReady),
    .M_HResp         (M_HResp),
    .HGrant          (HGrant),
    .irq             (irq),
    .C_config        (C_config),
    .HBusReq         (HBusReq),
    .con_sel         (con_sel),
    .con_en          (con_en),
    .channel_en_1    (channel_en_1),
    .channel_en_2    (channel_en_2),
    .config_write    (config_write),
    .config_HTrans   (config_HTrans),
    .addr_inc_sel    (addr_inc_sel),
    .DmacReq_Reg_en  (DmacReq_Reg_en),
    .PeriAddr_reg_en (PeriAddr_reg_en),
    .SAddr_Reg_en    (SAddr_Reg_en),
    .DAddr_Reg_en    (DAddr_Reg_en),
    .Trans_sz_Reg_en (Trans_sz_Reg_en),
    .Ctrl_Reg_en     (Ctrl_Reg_en),
    .cfg_err         (cfg_err)
  );

  task automatic chk(input string t,
                     input logic [7:0] o,
                     input logic [7:0] e);
    n_chk++;
    if (o !== e) begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             t, o, e);
    end
  endtask

  task automatic step(input string tag,
                      input logic [1:0] ht,
                      input logic [1:0] ai,
                      input logic [3:0] st);
    #1;
    chk({tag, "_ht"}, config_HTrans, ht);
    chk({tag, "_ai"}, addr_inc_sel, ai);
    chk({tag, "_stb"}, stb, st);
    @(negedge clk);
  endtask

  task automatic accept(input string tag,
                        input logic [1:0] req);
    DmacReq = req;
    #1;
    chk({tag, "_reqen"},
        {DmacReq_Reg_en, PeriAddr_reg_en}, 2'b11);
    @(negedge clk);
    DmacReq_Reg = req;
    #1;
    chk({tag, "_busreq"}, HBusReq, 1'b1);
    chk({tag, "_reqen0"},
        {DmacReq_Reg_en, PeriAddr_reg_en}, 2'b00);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    DmacReq = 2'b00;
    DmacReq_Reg = 2'b00;
    HReady = 1'b1;
    M_HResp = 2'b00;
    HGrant = 1'b0;
    irq = 1'b0;
    C_config = 1'b0;
    repeat (2) @(negedge clk);

    DmacReq = 2'b01;
    #1;
    chk("rst_consel", con_sel, 2'b10);
    chk("rst_hbus", HBusReq, 1'b0);
    chk("rst_ht", config_HTrans, 2'b00);
    chk("rst_chen", chen, 2'b00);
    chk("rst_reqen",
        {DmacReq_Reg_en, PeriAddr_reg_en}, 2'b00);
    chk("rst_misc",
        {con_en, config_write, cfg_err, stb}, 7'b0);
    @(negedge clk);
    rst = 1'b0;
    HGrant = 1'b1;

    accept("t1", 2'b01);
    chk("t1_c0_consel", con_sel, 2'b10);
    step("t1_c0", 2'b10, 2'd0, 4'b0000);
    step("t1_c1", 2'b11, 2'd1, 4'b1000);
    step("t1_c2", 2'b11, 2'd2, 4'b0100);
    step("t1_c3", 2'b11, 2'd3, 4'b0010);
    step("t1_c4", 2'b00, 2'd3, 4'b0001);
    #1;
    chk("t1_settle_en", con_en, 1'b1);
    chk("t1_settle_sel", con_sel, 2'b00);
    chk("t1_settle_chen", chen, 2'b00);
    @(negedge clk);
    #1;
    chk("t1_run_chen", chen, 2'b10);
    chk("t1_run_sel", con_sel, 2'b00);
    chk("t1_run_hbus", HBusReq, 1'b1);
    irq = 1'b1;
    #1;
    chk("t1_irq_chen", chen, 2'b10);
    @(negedge clk);
    irq = 1'b0;
    #1;
    chk("t1_rel_chen", chen, 2'b00);
    chk("t1_rel_hbus", HBusReq, 1'b0);
    chk("t1_rel_sel", con_sel, 2'b10);
    DmacReq = 2'b00;
    @(negedge clk);

    irq = 1'b1;
    #1;
    chk("idle_irq_chen", chen, 2'b00);
    chk("idle_irq_hbus", HBusReq, 1'b0);
    @(negedge clk);
    irq = 1'b0;
    #1;
    chk("idle_irq_hbus2", HBusReq, 1'b0);

    accept("t2", 2'b01);
    step("t2_c0", 2'b10, 2'd0, 4'b0000);
    step("t2_c1", 2'b11, 2'd1, 4'b1000);
    step("t2_c2", 2'b11, 2'd2, 4'b0100);
    HReady = 1'b0;
    step("t2_w0", 2'b11, 2'd3, 4'b0000);
    step("t2_w1", 2'b11, 2'd3, 4'b0000);
    HReady = 1'b1;
    step("t2_c3", 2'b11, 2'd3, 4'b0010);
    step("t2_c4", 2'b00, 2'd3, 4'b0001);
    @(negedge clk);
    #1;
    chk("t2_run_chen", chen, 2'b10);
    irq = 1'b1;
    @(negedge clk);
    irq = 1'b0;
    DmacReq = 2'b00;
    @(negedge clk);

    accept("t3", 2'b10);
    step("t3_c0", 2'b10, 2'd0, 4'b0000);
    chk("t3_c1_chen", chen, 2'b00);
    step("t3_c1", 2'b11, 2'd1, 4'b1000);
    step("t3_c2", 2'b11, 2'd2, 4'b0100);
    step("t3_c3", 2'b11, 2'd3, 4'b0010);
    C_config = 1'b1;
    step("t3_c4", 2'b00, 2'd3, 4'b0001);
    #1;
    chk("t3_settle_sel", con_sel, 2'b01);
    chk("t3_settle_en", con_en, 1'b1);
    @(negedge clk);
    #1;
    chk("t3_run_chen", chen, 2'b01);
    chk("t3_run_sel", con_sel, 2'b01);
    irq = 1'b1;
    @(negedge clk);
    irq = 1'b0;
    #1;
    chk("t3_rel_chen", chen, 2'b00);
    chk("t3_rel_reqen", DmacReq_Reg_en, 1'b0);
    @(negedge clk);
    #1;
    chk("t3_hold_reqen", DmacReq_Reg_en, 1'b0);
    chk("t3_hold_hbus", HBusReq, 1'b0);
    @(negedge clk);
    #1;
    chk("t3_hold2_reqen", DmacReq_Reg_en, 1'b0);
    DmacReq = 2'b00;
    @(negedge clk);

    accept("t5", 2'b10);
    step("t5_c0", 2'b10, 2'd0, 4'b0000);
    step("t5_c1", 2'b11, 2'd1, 4'b1000);
    HReady = 1'b0;
    M_HResp = 2'b01;
    #1;
    chk("t5_e1_stb", stb, 4'b0000);
    chk("t5_e1_err", cfg_err, 1'b1);
    chk("t5_e1_ht", config_HTrans, 2'b00);
    @(negedge clk);
    HReady = 1'b1;
    #1;
    chk("t5_e2_err", cfg_err, 1'b0);
    chk("t5_e2_stb", stb, 4'b0000);
    chk("t5_e2_hbus", HBusReq, 1'b0);
    chk("t5_e2_sel", con_sel, 2'b10);
    chk("t5_e2_chen", chen, 2'b00);
    M_HResp = 2'b00;
    DmacReq = 2'b00;
    @(negedge clk);
    @(negedge clk);

    C_config = 1'b0;
    accept("t6", 2'b01);
    step("t6_c0", 2'b10, 2'd0, 4'b0000);
    step("t6_c1", 2'b11, 2'd1, 4'b1000);
    step("t6_c2", 2'b11, 2'd2, 4'b0100);
    step("t6_c3", 2'b11, 2'd3, 4'b0010);
    step("t6_c4", 2'b00, 2'd3, 4'b0001);
    @(negedge clk);
    #1;
    chk("t6_run_chen", chen, 2'b10);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_rst_chen", chen, 2'b00);
    chk("t6_rst_hbus", HBusReq, 1'b0);
    chk("t6_rst_sel", con_sel, 2'b10);
    chk("t6_rst_reqen", DmacReq_Reg_en, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmac_req_ctrl.md
Name: dmac_req_ctrl

Overview:
- Control FSM that drives the DMAC main datapath.
- Accepts peripheral DMA requests and arbitrates for the AHB master port.
- Fetches the 4-word channel descriptor (SAddr, DAddr, Size, Ctrl) from the peripheral's config window at base+0xA0..0xAC.
- Enables the channel selected by Ctrl[16], then waits for irq and the peripheral's request release before accepting the next request.

Parameters:
- CFG_WORDS, 4: descriptor length in words. Only 4 is legal; it sizes the counters.
- HRESP_ERR, 2'b01: M_HResp encoding treated as an ERROR response.

Ports:
- clk  in  1  clock
- rst  in  1  async active-high reset
- DmacReq  in  2  peripheral request lines, level-sensitive
- DmacReq_Reg  in  2  latched request, from datapath
- HReady  in  1  AHB ready
- M_HResp  in  2  AHB response
- HGrant  in  1  bus grant
- irq  in  1  channel transfer complete
- C_config  in  1  Ctrl_Reg[16]; 0 selects channel 1, 1 selects channel 2
- HBusReq  out  1  bus request
- con_sel  out  2  datapath mux select: 00 ch1, 01 ch2, 10 config
- con_en  out  1  con_new_sel load strobe
- channel_en_1  out  1  channel 1 enable
- channel_en_2  out  1  channel 2 enable
- config_write  out  1  config-phase HWRITE, always 0
- config_HTrans  out  2  config-phase HTRANS
- addr_inc_sel  out  2  descriptor word index, address phase
- DmacReq_Reg_en, PeriAddr_reg_en  out  1 each  request/base latch strobes
- SAddr_Reg_en, DAddr_Reg_en, Trans_sz_Reg_en, Ctrl_Reg_en  out  1 each  descriptor capture strobes
- cfg_err  out  1  one-cycle pulse on descriptor fetch error

Behaviour:
- Reset values (async): state IDLE; all outputs 0 except con_sel=2'b10; config_HTrans=IDLE (00).
- IDLE:
  - If DmacReq!=0, pulse DmacReq_Reg_en and PeriAddr_reg_en for 1 cycle, then go to BUSREQ.
  - When DmacReq=11, both bits are latched; the datapath decodes 11 the same as 10.
- BUSREQ:
  - HBusReq=1. HBusReq stays high from here until the transfer completes or aborts (DONE or error).
  - When HGrant && HReady, go to CFG.
- CFG: address and data phases are pipelined; con_sel=10.
  - Address counter a (0..3): addr_inc_sel=a. config_HTrans=NONSEQ (10) for a=0, SEQ (11) for a=1..3. a increments when HReady=1.
  - After word 3 is accepted, config_HTrans=IDLE.
  - Data counter d (0..3) becomes valid the cycle after word 0 is accepted.
  - When HReady=1 and data is pending, exactly one strobe asserts combinationally, in order d=0..3: SAddr_Reg_en, DAddr_Reg_en, Trans_sz_Reg_en, Ctrl_Reg_en.
  - HReady=0 freezes a and d and suppresses all strobes.
  - Zero-wait fetch: NONSEQ cycle plus 4 cycles, so 5 cycles in CFG.
  - Once d=3 is captured, go to SETTLE.
- SETTLE:
  - 1 cycle, so C_config reflects the new Ctrl_Reg.
  - Drive con_sel=C_config?01:00 and pulse con_en, then go to RUN.
- RUN:
  - channel_en_1 or channel_en_2 held high, per the latched selection; con_sel held.
  - On irq=1, drop the channel enable next cycle and go to RELEASE.
- RELEASE:
  - HBusReq=0; con_sel=10; HTrans=IDLE.
  - Stay until (DmacReq & DmacReq_Reg)==0, then go to IDLE. This prevents re-triggering on the same level.
- Error:
  - M_HResp==HRESP_ERR in any CFG data phase: suppress that strobe, pulse cfg_err, drive HTrans=IDLE, go to RELEASE.
  - The second error cycle is ignored.
- Requests arriving outside IDLE are not queued; they are sampled again on return to IDLE.
- irq outside RUN is ignored.
- Reset mid-operation: all outputs return to reset values immediately; no bus release handshake.
- Exactly one of the capture strobes may be high in any cycle.
- channel_en_1 and channel_en_2 are never high together.

Decomposition:
- Package dmac_pkg:
  - state enum: IDLE, BUSREQ, CFG, SETTLE, RUN, RELEASE
  - HTRANS constants: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
  - con_sel constants: SEL_CH1=00, SEL_CH2=01, SEL_CFG=10
  - HRESP_OKAY, HRESP_ERR
- Sub-module dmac_cfg_fetch:
  - Contains the a/d counters and the strobe decode.
  - start in, done out, err out.
- The top-level FSM instantiates dmac_cfg_fetch once.

Test Plan:
- DmacReq=01, HGrant=1, HReady=1, Ctrl word bit16=0:
  - Strobes fire on consecutive cycles in order.
  - addr_inc_sel sequence 0,1,2,3; HTrans 10,11,11,11,00.
  - channel_en_1=1, con_sel=00. After irq, HBusReq=0.
- Same request with HReady low for 2 cycles during word 2:
  - a, d and addr_inc_sel hold.
  - No strobe while stalled; Trans_sz_Reg_en fires once afterwards.
- Ctrl bit16=1 → channel_en_2=1, con_sel=01; channel_en_1 stays 0 throughout.
- DmacReq held at 10 after irq → FSM stays in RELEASE. Dropping DmacReq → IDLE; a new request is then accepted.
- M_HResp=01 on word 1 data phase → DAddr_Reg_en stays 0, cfg_err pulses 1 cycle, no channel enabled, FSM goes to RELEASE.
- rst asserted during RUN → channel_en_x=0, HBusReq=0, con_sel=10 asynchronously.
